// File: rtl/qtcore_scan_loader_if.sv
// Host byte-stream bundle for the qtcore scan loader.
// tx_*: bytes into the chain (valid/ready); rx_*: readback bytes (pulse).
interface qtcore_scan_loader_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/qtcore_scan_loader.sv
// Scan-chain loader/readback and run control for the qtcore core.
// Ports: clk, rst_n, bus (byte stream), load/run requests, core scan/run pins.
module qtcore_scan_loader #(
  parameter int CHAIN_LEN = 176
) (
  input  logic clk,
  input  logic rst_n,
  qtcore_scan_loader_if.slave bus,
  input  logic load_start,
  input  logic run_start,
  output logic load_done,
  output logic busy,
  output logic scan_enable,
  output logic scan_in,
  input  logic scan_out,
  output logic proc_en,
  input  logic halt
);

  localparam int NBYTES = CHAIN_LEN / 8;
  localparam int BCW = $clog2(NBYTES + 1);
  localparam logic [BCW-1:0] NB_L = BCW'(NBYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_RUN,
    S_HALTED
  } state_t;

  state_t         r_state, w_state;
  logic [BCW-1:0] r_byte_cnt, w_byte_cnt;
  logic [2:0]     r_bit_cnt, w_bit_cnt;
  logic [7:0]     r_tx_sr, w_tx_sr;
  logic [7:0]     r_rx_sr, w_rx_sr;
  logic [7:0]     r_rx_data, w_rx_data;
  logic           r_rx_valid, w_rx_valid;
  logic           r_load_done, w_load_done;
  logic           r_busy, w_busy;
  logic           r_scan_en, w_scan_en;
  logic           r_scan_in, w_scan_in;
  logic           r_proc_en, w_proc_en;
  logic           r_tx_ready, w_tx_ready;
  logic           w_accept;

  assign w_accept = bus.tx_valid & r_tx_ready;

  // Every output is a flop; next values (including tx_ready for the
  // following cycle) are all derived here from the next-state view.
  always_comb begin
    w_state     = r_state;
    w_byte_cnt  = r_byte_cnt;
    w_bit_cnt   = r_bit_cnt;
    w_tx_sr     = r_tx_sr;
    w_rx_sr     = r_rx_sr;
    w_rx_data   = r_rx_data;
    w_rx_valid  = 1'b0;
    w_load_done = 1'b0;
    w_scan_en   = 1'b0;
    w_scan_in   = 1'b0;
    w_proc_en   = 1'b0;
    unique case (r_state)
      S_IDLE, S_HALTED: begin
        if (load_start) begin
          w_state    = S_SHIFT;
          w_byte_cnt = '0;
          w_bit_cnt  = '0;
        end else if (run_start) begin
          w_state   = S_RUN;
          w_proc_en = 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_scan_en) begin
          w_rx_sr = {r_rx_sr[6:0], scan_out};
          if (r_bit_cnt != 3'd7) begin
            w_scan_en = 1'b1;
            w_scan_in = r_tx_sr[7];
            w_tx_sr   = {r_tx_sr[6:0], 1'b0};
            w_bit_cnt = r_bit_cnt + 3'd1;
          end else begin
            w_rx_data  = w_rx_sr;
            w_rx_valid = 1'b1;
            if (r_byte_cnt == NB_L) begin
              w_state     = S_IDLE;
              w_load_done = 1'b1;
            end
          end
        end
        // A byte accepted on the 8th shift edge chains straight on.
        if (w_accept) begin
          w_scan_en  = 1'b1;
          w_scan_in  = bus.tx_data[7];
          w_tx_sr    = {bus.tx_data[6:0], 1'b0};
          w_bit_cnt  = '0;
          w_byte_cnt = r_byte_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (halt) begin
          w_state = S_HALTED;
        end else begin
          w_proc_en = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state == S_SHIFT) || (w_state == S_RUN);
    w_tx_ready = (w_state == S_SHIFT)
               && (!w_scan_en || (w_bit_cnt == 3'd7))
               && (w_byte_cnt < NB_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_load_done <= 1'b0;
      r_busy      <= 1'b0;
      r_scan_en   <= 1'b0;
      r_scan_in   <= 1'b0;
      r_proc_en   <= 1'b0;
      r_tx_ready  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_byte_cnt  <= w_byte_cnt;
      r_bit_cnt   <= w_bit_cnt;
      r_tx_sr     <= w_tx_sr;
      r_rx_sr     <= w_rx_sr;
      r_rx_data   <= w_rx_data;
      r_rx_valid  <= w_rx_valid;
      r_load_done <= w_load_done;
      r_busy      <= w_busy;
      r_scan_en   <= w_scan_en;
      r_scan_in   <= w_scan_in;
      r_proc_en   <= w_proc_en;
      r_tx_ready  <= w_tx_ready;
    end
  end

  assign bus.tx_ready = r_tx_ready;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign load_done    = r_load_done;
  assign busy         = r_busy;
  assign scan_enable  = r_scan_en;
  assign scan_in      = r_scan_in;
  assign proc_en      = r_proc_en;

endmodule

// File: tb/tb_qtcore_scan_loader.sv
// Testbench for qtcore_scan_loader with a 16-bit loopback chain model.
// Scoreboard queues hold expected scan_in bits and readback bytes.
module tb_qtcore_scan_loader;
  localparam int CL = 16;
  localparam int NB = CL / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_start = 1'b0;
  logic run_start = 1'b0;
  logic load_done, busy, scan_enable, scan_in, scan_out, proc_en;
  logic halt = 1'b0;

  always #5 clk = ~clk;

  qtcore_scan_loader_if bif();

  qtcore_scan_loader #(.CHAIN_LEN(CL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bif),
    .load_start  (load_start),
    .run_start   (run_start),
    .load_done   (load_done),
    .busy        (busy),
    .scan_enable (scan_enable),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .proc_en     (proc_en),
    .halt        (halt)
  );

  // core scan chain stand-in
  logic [CL-1:0] chain;
  logic          preload_req = 1'b1;
  assign scan_out = chain[CL-1];
  always @(posedge clk) begin
    if (preload_req) chain <= 16'hF00F;
    else if (scan_enable) chain <= {chain[CL-2:0], scan_in};
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic      q_bits[$];
  logic [7:0] q_rx[$];
  int n_shift = 0, n_gap = 0, n_rxv = 0, n_done = 0, n_proc = 0;
  logic prev_se = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("excl", {31'd0, scan_enable & proc_en}, 0);
      if (scan_enable) begin
        n_shift++;
        check("bitq_nonempty", {31'd0, q_bits.size() > 0}, 1);
        if (q_bits.size() > 0) check("scan_in", {31'd0, scan_in}, {31'd0, q_bits.pop_front()});
      end else if (busy) begin
        n_gap++;
      end
      if (bif.rx_valid) begin
        n_rxv++;
        check("rx_lat", {31'd0, prev_se}, 1);
        check("rxq_nonempty", {31'd0, q_rx.size() > 0}, 1);
        if (q_rx.size() > 0) check("rx_data", {24'd0, bif.rx_data}, {24'd0, q_rx.pop_front()});
      end
      if (load_done) begin
        n_done++;
        check("done_rxv", {31'd0, bif.rx_valid}, 1);
        check("done_busy", {31'd0, busy}, 0);
      end
      if (proc_en) n_proc++;
      prev_se = scan_enable;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] exp_rx);
    int n = 0;
    bif.tx_data = b;
    bif.tx_valid = 1'b1;
    while (!bif.tx_ready && n < 50) begin
      tick(1);
      n++;
    end
    check("send_timeout", {31'd0, bif.tx_ready}, 1);
    if (bif.tx_ready) begin
      for (int k = 7; k >= 0; k--) q_bits.push_back(b[k]);
      q_rx.push_back(exp_rx);
    end
    tick(1);
    bif.tx_valid = 1'b0;
  endtask

  task automatic do_load(input logic [CL-1:0] data, input int stall,
                         input logic with_run);
    logic [CL-1:0] snap;
    int b_sh, b_gap, b_done, b_rxv, b_proc, n;
    snap = chain;
    b_sh = n_shift; b_gap = n_gap; b_done = n_done;
    b_rxv = n_rxv; b_proc = n_proc;
    load_start = 1'b1;
    run_start = with_run;
    tick(1);
    load_start = 1'b0;
    run_start = 1'b0;
    check("ld_busy", {31'd0, busy}, 1);
    check("ld_ready", {31'd0, bif.tx_ready}, 1);
    check("ld_proc", {31'd0, proc_en}, 0);
    for (int i = 0; i < NB; i++) begin
      if (i > 0 && stall > 0) tick(7 + stall);
      send(data[CL-1-8*i -: 8], snap[CL-1-8*i -: 8]);
    end
    n = 0;
    while (!load_done && n < 20) begin
      tick(1);
      n++;
    end
    check("ld_done_seen", {31'd0, load_done}, 1);
    tick(1);
    check("ld_chain", {16'd0, chain}, {16'd0, data});
    check("ld_shifts", n_shift - b_sh, CL);
    check("ld_gap", n_gap - b_gap, 1 + stall);
    check("ld_done_cnt", n_done - b_done, 1);
    check("ld_rxv_cnt", n_rxv - b_rxv, NB);
    check("ld_no_proc", n_proc - b_proc, 0);
    check("ld_ready_end", {31'd0, bif.tx_ready}, 0);
    check("ld_q_empty", q_bits.size() + q_rx.size(), 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_se"}, {31'd0, scan_enable}, 0);
    check({tag, "_pe"}, {31'd0, proc_en}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_rdy"}, {31'd0, bif.tx_ready}, 0);
    check({tag, "_rxv"}, {31'd0, bif.rx_valid}, 0);
    check({tag, "_done"}, {31'd0, load_done}, 0);
  endtask

  initial begin
    int b_proc, b_rxv, b_done;
    bif.tx_data = 8'h00;
    bif.tx_valid = 1'b0;
    tick(3);
    preload_req = 1'b0;
    check_quiet("rst");
    check("rst_rxdata", {24'd0, bif.rx_data}, 0);
    check("rst_scanin", {31'd0, scan_in}, 0);
    rst_n = 1'b1;
    tick(1);

    // tx_valid in IDLE is ignored
    bif.tx_valid = 1'b1;
    bif.tx_data = 8'hFF;
    tick(3);
    check_quiet("idle_tx");
    bif.tx_valid = 1'b0;

    // back-to-back loopback load, then one with a 5-cycle stall
    do_load(16'hA53C, 0, 1'b0);
    do_load(16'h5AC3, 5, 1'b0);

    // run for 10 cycles then halt
    b_proc = n_proc;
    run_start = 1'b1;
    tick(1);
    run_start = 1'b0;
    check("run_pe", {31'd0, proc_en}, 1);
    check("run_busy", {31'd0, busy}, 1);
    tick(9);
    halt = 1'b1;
    tick(3);
    check("run_cycles", n_proc - b_proc, 10);
    check("halt_pe", {31'd0, proc_en}, 0);
    check("halt_busy", {31'd0, busy}, 0);

    // both requests in HALTED: load wins
    do_load(16'h1234, 0, 1'b1);

    // halt already high on the first RUN cycle
    b_proc = n_proc;
    run_start = 1'b1;
    tick(1);
    run_start = 1'b0;
    tick(3);
    check("halt_first", n_proc - b_proc, 1);
    halt = 1'b0;

    // reset during RUN
    run_start = 1'b1;
    tick(1);
    run_start = 1'b0;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("rst_run");
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check_quiet("post_rst_run");

    // reset during the 3rd bit of byte 1
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
    send(8'h96, chain[15:8]);
    send(8'h69, chain[7:0]);
    tick(2);
    check("mid_se", {31'd0, scan_enable}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("rst_shift");
    q_bits.delete();
    q_rx.delete();
    b_rxv = n_rxv;
    b_done = n_done;
    tick(1);
    rst_n = 1'b1;
    bif.tx_valid = 1'b1;
    bif.tx_data = 8'hFF;
    tick(5);
    check_quiet("post_rst_shift");
    check("post_rst_rxv", n_rxv - b_rxv, 0);
    check("post_rst_done", n_done - b_done, 0);
    bif.tx_valid = 1'b0;

    // full reload recovers the chain
    do_load(16'hC35A, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
